jtframe_dip_sched: RTL and testbench
====================================

Name: jtframe_dip_sched

Overview:
- Schedules how OSD/HPS status words are applied to the frame's DIP decoding logic.
- Assembles a 32-bit status word from byte writes into a shadow register.
- Commits the shadow to the live status only at the start of vertical blank, so scanline, aspect and rotation settings never change mid-frame.
- Raises a timed reset request when reset-relevant bits change, and generates game_pause from a debounced pause button.

Parameters:
- COMMIT_VB, 1: 1 = commit on vb rising edge; 0 = commit on the cycle after a complete word arrives.
- RST_MASK, 32'h0000_0001: status bits whose change on commit triggers rst_req.
- RST_LEN, 8: rst_req high time in clk cycles; range 1..255.
- DEBOUNCE_W, 16: debounce counter width. The button must be stable for 2^DEBOUNCE_W cycles.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- byte_we  in  1  shadow byte write strobe
- byte_addr  in  2  byte lane; 0 = status[7:0] .. 3 = status[31:24]
- byte_din  in  8  byte data
- vb  in  1  vertical blank, synchronous to clk
- pause_btn  in  1  raw asynchronous pause button, active-high
- status  out  32  committed status word, feeds DIP decoding
- status_upd  out  1  one-cycle pulse on each commit
- rst_req  out  1  core reset request
- game_pause  out  1  pause toggle state

Behaviour:
- Reset (rst_n low, asynchronous): the following all clear.
  - Outputs: status=0, status_upd=0, rst_req=0, game_pause=0.
  - Internal: shadow=0, pending=0, FSM=IDLE, vb_l=0, synchroniser, debounce counter and debounced level.
- Reset mid-operation discards any pending word; no commit follows reset release.
- Shadow assembly:
  - When byte_we=1, shadow[8*byte_addr +: 8] <= byte_din.
  - Only a write to lane 3 sets pending; lanes 0..2 alone never commit.
- FSM states are IDLE, WAIT_VB, COMMIT, RST_HOLD.
  - IDLE: if pending, go to WAIT_VB when COMMIT_VB=1, otherwise to COMMIT.
  - WAIT_VB: stay until vb=1 && vb_l=0 (rising edge, vb_l = vb registered), then go to COMMIT. If vb is already high on entry, wait for the next rising edge.
  - COMMIT (1 cycle):
    - status <= shadow, status_upd=1, pending cleared.
    - If ((status ^ shadow) & RST_MASK) != 0, load cnt=RST_LEN and go to RST_HOLD; otherwise go to IDLE.
  - RST_HOLD: rst_req=1 each cycle; cnt decrements; leave to IDLE after RST_LEN cycles. Total rst_req width is exactly RST_LEN.
- Latency:
  - With COMMIT_VB=0, status changes 2 cycles after the lane-3 write cycle.
  - With COMMIT_VB=1, status updates 1 cycle after the vb rising-edge cycle.
- Writes during WAIT_VB update shadow; the commit uses the latest shadow.
- Write in the COMMIT cycle: the commit uses the pre-write shadow. The write lands in shadow. A lane-3 write re-sets pending, because set wins over clear.
- A pending word arriving during RST_HOLD is serviced after return to IDLE.
- Pause path:
  - pause_btn passes through a 2-FF synchroniser, then the debouncer.
  - The debounced level changes only after the synced input differs from it for 2^DEBOUNCE_W consecutive cycles. Any glitch restarts the counter.
  - A debounced rising edge toggles game_pause.
  - game_pause is forced to 0 on any cycle where rst_req=1; this has priority over a toggle.
- All outputs are registered.

Decomposition:
- Package jtframe_dip_pkg holds:
  - state enum {IDLE, WAIT_VB, COMMIT, RST_HOLD}, 2 bits;
  - lane constants LANE_LO=0, LANE_HI=3;
  - status bit indices STATUS_RST=0, STATUS_PAUSE=1, STATUS_SCAN_LSB=3, STATUS_FLIP=12, STATUS_TATE=13.
- Sub-module jtframe_debounce (parameter W) contains the synchroniser, counter and level output. The pause edge/toggle logic stays in the parent.

Test Plan:
- Lane-order write with COMMIT_VB=1: write lanes 0,1,2,3 = 00,20,00,00 with vb low, then raise vb.
  - status stays 0 until vb rises; then status=32'h0000_2000 and a single status_upd pulse.
  - rst_req stays 0.
- Reset-bit change with RST_LEN=8: commit word 32'h1 when status=0.
  - rst_req high for exactly 8 cycles, starting the cycle after status_upd.
  - A second commit of 32'h0 gives another 8-cycle pulse.
- Partial write: write lanes 0..2 only, then toggle vb several times.
  - No commit, status unchanged.
  - A later lane-3 write commits all four bytes.
- Same-cycle write with COMMIT_VB=0: lane-3 write coincides with the COMMIT cycle.
  - First commit uses the old shadow.
  - A second commit follows, with status_upd pulsing twice.
- Debounce with DEBOUNCE_W=4: pause_btn glitch of 10 cycles does nothing.
  - A press held 40 cycles toggles game_pause to 1; the release leaves it 1.
  - A second press returns it to 0.
  - game_pause=1 when rst_req asserts clears it to 0.
- Async reset mid-operation: assert rst_n low while in WAIT_VB with a pending word.
  - All outputs are 0 immediately, without waiting for a clock.
  - After release no commit occurs on the next vb rising edge.

Source files
------------

// File: rtl/jtframe_dip_pkg.sv
// Shared types and constants for the DIP status scheduler.
package jtframe_dip_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_VB  = 2'd1,
    COMMIT   = 2'd2,
    RST_HOLD = 2'd3
  } state_t;

  localparam logic [1:0] LANE_LO = 2'd0;
  localparam logic [1:0] LANE_HI = 2'd3;

  localparam int unsigned STATUS_RST      = 0;
  localparam int unsigned STATUS_PAUSE    = 1;
  localparam int unsigned STATUS_SCAN_LSB = 3;
  localparam int unsigned STATUS_FLIP     = 12;
  localparam int unsigned STATUS_TATE     = 13;

  // Replace one byte lane of a 32-bit word.
  function automatic logic [31:0] put_byte(input logic [31:0] word, input logic [1:0] lane,
                                           input logic [7:0] data);
    logic [31:0] res;
    res = word;
    res[8*lane +: 8] = data;
    return res;
  endfunction

endpackage

// File: rtl/jtframe_debounce.sv
// Two-flop synchroniser followed by a stability counter. The level output only follows the
// synced input after it has differed from the level for 2^W consecutive cycles.
module jtframe_debounce #(
  parameter int unsigned W = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic level_o
);

  logic [1:0]   sync_q;
  logic [W-1:0] cnt_q;
  logic         level_q;

  // Bring the raw button into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], btn_i};
    end
  end

  // Count consecutive disagreeing cycles; any agreeing cycle restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else if (sync_q[1] != level_q) begin
      if (&cnt_q) begin
        level_q <= sync_q[1];
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end else begin
      cnt_q <= '0;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/jtframe_dip_sched.sv
// Assembles byte writes into a shadow status word and commits it to the live status at a
// safe point (vertical blank, or right away), with a timed reset request on relevant changes
// and a debounced pause toggle.
module jtframe_dip_sched
  import jtframe_dip_pkg::*;
#(
  parameter bit           COMMIT_VB  = 1'b1,
  parameter logic [31:0]  RST_MASK   = 32'h0000_0001,
  parameter int unsigned  RST_LEN    = 8,
  parameter int unsigned  DEBOUNCE_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        byte_we,
  input  logic [1:0]  byte_addr,
  input  logic [7:0]  byte_din,
  input  logic        vb,
  input  logic        pause_btn,
  output logic [31:0] status,
  output logic        status_upd,
  output logic        rst_req,
  output logic        game_pause
);

  localparam logic [7:0] RstCnt = 8'(RST_LEN);

  state_t      state_q;
  logic [31:0] shadow_q;
  logic        pending_q;
  logic        vb_l;
  logic [7:0]  cnt_q;
  logic        pause_lvl;
  logic        pause_lvl_q;

  // Shadow byte assembly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
    end else if (byte_we) begin
      shadow_q <= put_byte(shadow_q, byte_addr, byte_din);
    end
  end

  // Only a top-lane write marks a complete word; a new word beats the commit's clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= 1'b0;
    end else if (byte_we && byte_addr == LANE_HI) begin
      pending_q <= 1'b1;
    end else if (state_q == COMMIT) begin
      pending_q <= 1'b0;
    end
  end

  // Delayed vb for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vb_l <= 1'b0;
    end else begin
      vb_l <= vb;
    end
  end

  // Commit scheduler with registered status, update pulse and reset request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      status     <= '0;
      status_upd <= 1'b0;
      rst_req    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      status_upd <= 1'b0;
      rst_req    <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pending_q) state_q <= COMMIT_VB ? WAIT_VB : COMMIT;
        end
        WAIT_VB: begin
          if (vb && !vb_l) state_q <= COMMIT;
        end
        COMMIT: begin
          status     <= shadow_q;
          status_upd <= 1'b1;
          if (|((status ^ shadow_q) & RST_MASK)) begin
            cnt_q   <= RstCnt;
            state_q <= RST_HOLD;
          end else begin
            state_q <= IDLE;
          end
        end
        RST_HOLD: begin
          rst_req <= 1'b1;
          cnt_q   <= cnt_q - 1'b1;
          if (cnt_q == 8'd1) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  jtframe_debounce #(
    .W (DEBOUNCE_W)
  ) u_debounce (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_i   (pause_btn),
    .level_o (pause_lvl)
  );

  // Pause toggles on a debounced press. rst_req is high exactly on the cycles after RST_HOLD
  // edges, so clearing on RST_HOLD keeps game_pause low on every rst_req cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pause_lvl_q <= 1'b0;
      game_pause  <= 1'b0;
    end else begin
      pause_lvl_q <= pause_lvl;
      if (state_q == RST_HOLD) begin
        game_pause <= 1'b0;
      end else if (pause_lvl && !pause_lvl_q) begin
        game_pause <= ~game_pause;
      end
    end
  end

endmodule

// File: tb/tb_jtframe_dip_sched.sv
// Two instances share stimulus: index 0 commits immediately, index 1 commits on vb.
module tb_jtframe_dip_sched;

  localparam int          RLEN = 8;
  localparam logic [31:0] MASK = 32'h0000_0001;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       byte_we = 1'b0;
  logic [1:0] byte_addr = 2'd0;
  logic [7:0] byte_din = 8'd0;
  logic       vb = 1'b0;
  logic       pause_btn = 1'b0;

  logic [31:0] status_w [2];
  logic        upd_w [2];
  logic        rst_w [2];
  logic        pause_w [2];

  int vectors = 0;
  int miscompares = 0;

  // Reference model: commits scheduled by edge index
  int          n = 0;
  logic [31:0] m_shadow;
  logic [31:0] m_status [2];
  bit          m_pending [2];
  bit          m_upd [2];
  bit          m_rst [2];
  bit          m_wait [2];
  int          m_commit_at [2];
  int          m_idle_at [2];
  int          m_rst_from [2];
  int          m_rst_to [2];
  bit          m_vb_l;

  always #5 clk = ~clk;

  jtframe_dip_sched #(
    .COMMIT_VB (1'b0), .RST_MASK (MASK), .RST_LEN (RLEN), .DEBOUNCE_W (4)
  ) u_imm (
    .clk (clk), .rst_n (rst_n), .byte_we (byte_we), .byte_addr (byte_addr),
    .byte_din (byte_din), .vb (vb), .pause_btn (pause_btn), .status (status_w[0]),
    .status_upd (upd_w[0]), .rst_req (rst_w[0]), .game_pause (pause_w[0])
  );

  jtframe_dip_sched #(
    .COMMIT_VB (1'b1), .RST_MASK (MASK), .RST_LEN (RLEN), .DEBOUNCE_W (4)
  ) u_vb (
    .clk (clk), .rst_n (rst_n), .byte_we (byte_we), .byte_addr (byte_addr),
    .byte_din (byte_din), .vb (vb), .pause_btn (pause_btn), .status (status_w[1]),
    .status_upd (upd_w[1]), .rst_req (rst_w[1]), .game_pause (pause_w[1])
  );

  task automatic model_reset();
    m_shadow = '0;
    m_vb_l   = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_status[i]    = '0;
      m_pending[i]   = 1'b0;
      m_upd[i]       = 1'b0;
      m_rst[i]       = 1'b0;
      m_wait[i]      = 1'b0;
      m_commit_at[i] = -1;
      m_idle_at[i]   = 0;
      m_rst_from[i]  = -1;
      m_rst_to[i]    = -2;
    end
  endtask

  task automatic model_step(input bit we, input logic [1:0] a, input logic [7:0] d, input bit v);
    if (!rst_n) begin
      model_reset();
      return;
    end
    n++;
    for (int i = 0; i < 2; i++) begin
      m_upd[i] = 1'b0;
      if (m_commit_at[i] == n) begin
        if (((m_status[i] ^ m_shadow) & MASK) != 0) begin
          m_rst_from[i] = n + 1;
          m_rst_to[i]   = n + RLEN;
          m_idle_at[i]  = n + RLEN + 1;
        end else begin
          m_idle_at[i] = n + 1;
        end
        m_status[i]  = m_shadow;
        m_upd[i]     = 1'b1;
        m_pending[i] = 1'b0;
      end else if (m_wait[i]) begin
        if (v && !m_vb_l) begin
          m_commit_at[i] = n + 1;
          m_wait[i]      = 1'b0;
        end
      end else if (n >= m_idle_at[i] && m_commit_at[i] < n && m_pending[i]) begin
        if (i == 1) m_wait[i] = 1'b1;
        else        m_commit_at[i] = n + 1;
      end
      m_rst[i] = (n >= m_rst_from[i]) && (n <= m_rst_to[i]);
      if (we && a == 2'd3) m_pending[i] = 1'b1;
    end
    if (we) m_shadow[8*a +: 8] = d;
    m_vb_l = v;
  endtask

  task automatic tick(input bit we, input logic [1:0] a, input logic [7:0] d, input bit v);
    byte_we   = we;
    byte_addr = a;
    byte_din  = d;
    vb        = v;
    @(posedge clk);
    model_step(we, a, d, v);
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) tick(1'b0, 2'd0, 8'd0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if ({status_w[i], upd_w[i], rst_w[i], pause_w[i]} !== 35'd0) begin
        miscompares++;
        $display("FAIL reset[%0d]: got status=%h upd=%b rst=%b pause=%b, expected all 0", i,
                 status_w[i], upd_w[i], rst_w[i], pause_w[i]);
      end
    end
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) tick(1'b0, 2'd0, 8'd0, 1'b0);
  endtask

  task automatic test_lane_order();
    int upd_cnt = 0;
    bit saw_rst = 1'b0;
    bit v;
    for (int k = 0; k < 4; k++) tick(1'b1, 2'(k), (k == 1) ? 8'h20 : 8'h00, 1'b0);
    for (int c = 0; c < 16; c++) begin
      v = (c >= 6 && c < 10);
      tick(1'b0, 2'd0, 8'd0, v);
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (status_w[i] !== m_status[i] || upd_w[i] !== m_upd[i] || rst_w[i] !== m_rst[i]) begin
          miscompares++;
          $display("FAIL lane_order_model[%0d] c=%0d: got %h/%b/%b expected %h/%b/%b", i, c,
                   status_w[i], upd_w[i], rst_w[i], m_status[i], m_upd[i], m_rst[i]);
        end
      end
      if (upd_w[1]) upd_cnt++;
      if (rst_w[0] || rst_w[1]) saw_rst = 1'b1;
      vectors++;
      if (c <= 6 && status_w[1] !== 32'h0) begin
        miscompares++;
        $display("FAIL hold_until_vb c=%0d: got %h expected 00000000", c, status_w[1]);
      end else if (c >= 7 && status_w[1] !== 32'h0000_2000) begin
        miscompares++;
        $display("FAIL commit_on_vb c=%0d: got %h expected 00002000", c, status_w[1]);
      end
    end
    vectors++;
    if (upd_cnt != 1) begin
      miscompares++;
      $display("FAIL single_upd: got %0d pulses expected 1", upd_cnt);
    end
    vectors++;
    if (saw_rst) begin
      miscompares++;
      $display("FAIL no_rst_req: got rst_req=1 expected 0");
    end
    vectors++;
    if (status_w[0] !== 32'h0000_2000) begin
      miscompares++;
      $display("FAIL imm_commit: got %h expected 00002000", status_w[0]);
    end
  endtask

  task automatic test_rst_bit();
    logic [31:0] word;
    int upd_at [2];
    int rst_first [2];
    int rst_last [2];
    int rst_cnt [2];
    bit v;
    for (int k = 0; k < 2; k++) begin
      word = (k == 0) ? 32'h1 : 32'h0;
      for (int l = 0; l < 4; l++) tick(1'b1, 2'(l), word[8*l +: 8], 1'b0);
      for (int i = 0; i < 2; i++) begin
        upd_at[i] = -100; rst_first[i] = -1; rst_last[i] = -1; rst_cnt[i] = 0;
      end
      for (int c = 0; c < 40; c++) begin
        v = (c >= 5 && c < 8);
        tick(1'b0, 2'd0, 8'd0, v);
        for (int i = 0; i < 2; i++) begin
          vectors++;
          if (status_w[i] !== m_status[i] || upd_w[i] !== m_upd[i] || rst_w[i] !== m_rst[i]) begin
            miscompares++;
            $display("FAIL rst_model[%0d] c=%0d: got %h/%b/%b expected %h/%b/%b", i, c,
                     status_w[i], upd_w[i], rst_w[i], m_status[i], m_upd[i], m_rst[i]);
          end
          if (upd_w[i]) upd_at[i] = c;
          if (rst_w[i]) begin
            rst_cnt[i]++;
            if (rst_first[i] < 0) rst_first[i] = c;
            rst_last[i] = c;
          end
        end
      end
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (rst_cnt[i] != RLEN || rst_first[i] != upd_at[i] + 1
            || rst_last[i] != upd_at[i] + RLEN) begin
          miscompares++;
          $display("FAIL rst_width[%0d] k=%0d: got %0d cycles from %0d to %0d (upd %0d), expected 8 from upd+1",
                   i, k, rst_cnt[i], rst_first[i], rst_last[i], upd_at[i]);
        end
        vectors++;
        if (status_w[i] !== word) begin
          miscompares++;
          $display("FAIL rst_status[%0d]: got %h expected %h", i, status_w[i], word);
        end
      end
    end
  endtask

  task automatic test_partial();
    logic [31:0] word;
    logic [31:0] prev [2];
    bit v;
    word = $urandom;
    prev[0] = m_status[0];
    prev[1] = m_status[1];
    for (int k = 0; k < 3; k++) tick(1'b1, 2'(k), word[8*k +: 8], 1'b0);
    for (int c = 0; c < 30; c++) begin
      v = (c % 10) >= 5;
      tick(1'b0, 2'd0, 8'd0, v);
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (status_w[i] !== prev[i] || upd_w[i] !== 1'b0) begin
          miscompares++;
          $display("FAIL partial_hold[%0d] c=%0d: got %h upd=%b expected %h upd=0", i, c,
                   status_w[i], upd_w[i], prev[i]);
        end
      end
    end
    tick(1'b1, 2'd3, word[31:24], 1'b0);
    for (int c = 0; c < 30; c++) begin
      v = (c >= 4 && c < 7);
      tick(1'b0, 2'd0, 8'd0, v);
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (status_w[i] !== m_status[i] || upd_w[i] !== m_upd[i] || rst_w[i] !== m_rst[i]) begin
          miscompares++;
          $display("FAIL partial_model[%0d] c=%0d: got %h/%b/%b expected %h/%b/%b", i, c,
                   status_w[i], upd_w[i], rst_w[i], m_status[i], m_upd[i], m_rst[i]);
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (status_w[i] !== word) begin
        miscompares++;
        $display("FAIL partial_commit[%0d]: got %h expected %h", i, status_w[i], word);
      end
    end
  endtask

  task automatic test_same_cycle();
    logic [31:0] word_a;
    logic [31:0] word_b;
    int upd_cnt = 0;
    word_a = {8'h11, m_shadow[23:0]};
    word_b = {8'h22, m_shadow[23:0]};
    for (int c = 0; c < 12; c++) begin
      if (c == 0)      tick(1'b1, 2'd3, 8'h11, 1'b0);
      else if (c == 2) tick(1'b1, 2'd3, 8'h22, 1'b0);
      else             tick(1'b0, 2'd0, 8'd0, 1'b0);
      if (upd_w[0]) upd_cnt++;
      vectors++;
      if (status_w[0] !== m_status[0] || upd_w[0] !== m_upd[0] || rst_w[0] !== m_rst[0]) begin
        miscompares++;
        $display("FAIL same_cycle_model c=%0d: got %h/%b/%b expected %h/%b/%b", c,
                 status_w[0], upd_w[0], rst_w[0], m_status[0], m_upd[0], m_rst[0]);
      end
      if (c == 2 || c == 3) begin
        vectors++;
        if (status_w[0] !== word_a) begin
          miscompares++;
          $display("FAIL first_commit_old c=%0d: got %h expected %h", c, status_w[0], word_a);
        end
      end
      if (c == 4) begin
        vectors++;
        if (status_w[0] !== word_b || upd_w[0] !== 1'b1) begin
          miscompares++;
          $display("FAIL second_commit: got %h upd=%b expected %h upd=1", status_w[0],
                   upd_w[0], word_b);
        end
      end
    end
    vectors++;
    if (upd_cnt != 2) begin
      miscompares++;
      $display("FAIL double_upd: got %0d pulses expected 2", upd_cnt);
    end
    // flush the vb instance
    for (int c = 0; c < 25; c++) tick(1'b0, 2'd0, 8'd0, (c >= 2 && c < 5));
    vectors++;
    if (status_w[1] !== word_b) begin
      miscompares++;
      $display("FAIL vb_latest_shadow: got %h expected %h", status_w[1], word_b);
    end
  endtask

  task automatic press(input int len, input bit expect_after);
    pause_btn = 1'b1;
    for (int c = 0; c < len; c++) begin
      tick(1'b0, 2'd0, 8'd0, 1'b0);
      if (c == 14) begin
        for (int i = 0; i < 2; i++) begin
          vectors++;
          if (pause_w[i] !== ~expect_after) begin
            miscompares++;
            $display("FAIL pause_early[%0d]: got %b expected %b", i, pause_w[i], ~expect_after);
          end
        end
      end
    end
    pause_btn = 1'b0;
    for (int c = 0; c < 40; c++) tick(1'b0, 2'd0, 8'd0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (pause_w[i] !== expect_after) begin
        miscompares++;
        $display("FAIL pause_level[%0d] len=%0d: got %b expected %b", i, len, pause_w[i],
                 expect_after);
      end
    end
  endtask

  task automatic test_debounce();
    press(10, 1'b0);
    // two 10-cycle glitches split by one low cycle must not add up
    pause_btn = 1'b1;
    for (int c = 0; c < 10; c++) tick(1'b0, 2'd0, 8'd0, 1'b0);
    pause_btn = 1'b0;
    tick(1'b0, 2'd0, 8'd0, 1'b0);
    press(10, 1'b0);
    press(40, 1'b1);
    press(40, 1'b0);
    press(40, 1'b1);
  endtask

  task automatic test_pause_clear();
    bit saw_rst [2];
    bit v;
    saw_rst[0] = 1'b0;
    saw_rst[1] = 1'b0;
    tick(1'b1, 2'd0, m_shadow[7:0] ^ 8'h01, 1'b0);
    tick(1'b1, 2'd3, m_shadow[31:24], 1'b0);
    for (int c = 0; c < 40; c++) begin
      v = (c >= 5 && c < 8);
      tick(1'b0, 2'd0, 8'd0, v);
      for (int i = 0; i < 2; i++) begin
        if (rst_w[i]) begin
          saw_rst[i] = 1'b1;
          vectors++;
          if (pause_w[i] !== 1'b0) begin
            miscompares++;
            $display("FAIL pause_during_rst[%0d] c=%0d: got %b expected 0", i, c, pause_w[i]);
          end
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (!saw_rst[i] || pause_w[i] !== 1'b0) begin
        miscompares++;
        $display("FAIL pause_cleared[%0d]: got rst_seen=%b pause=%b expected 1 and 0", i,
                 saw_rst[i], pause_w[i]);
      end
    end
  endtask

  task automatic test_random();
    bit v = 1'b0;
    bit we;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 7) == 0) v = ~v;
      we = ($urandom_range(0, 2) == 0);
      tick(we, 2'($urandom_range(0, 3)), 8'($urandom), v);
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (status_w[i] !== m_status[i] || upd_w[i] !== m_upd[i] || rst_w[i] !== m_rst[i]) begin
          miscompares++;
          $display("FAIL random_model[%0d] c=%0d: got %h/%b/%b expected %h/%b/%b", i, c,
                   status_w[i], upd_w[i], rst_w[i], m_status[i], m_upd[i], m_rst[i]);
        end
      end
    end
    for (int c = 0; c < 20; c++) tick(1'b0, 2'd0, 8'd0, 1'b0);
  endtask

  task automatic test_async_reset();
    int upd_cnt = 0;
    tick(1'b1, 2'd3, 8'hA5, 1'b0);
    for (int c = 0; c < 30; c++) tick(1'b0, 2'd0, 8'd0, (c >= 3 && c < 6));
    tick(1'b1, 2'd3, 8'h5A, 1'b0);
    for (int c = 0; c < 3; c++) tick(1'b0, 2'd0, 8'd0, 1'b0);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if ({status_w[i], upd_w[i], rst_w[i], pause_w[i]} !== 35'd0) begin
        miscompares++;
        $display("FAIL async_reset[%0d]: got status=%h upd=%b rst=%b pause=%b expected all 0",
                 i, status_w[i], upd_w[i], rst_w[i], pause_w[i]);
      end
    end
    tick(1'b0, 2'd0, 8'd0, 1'b0);
    tick(1'b0, 2'd0, 8'd0, 1'b0);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick(1'b0, 2'd0, 8'd0, (c >= 3 && c < 6));
      for (int i = 0; i < 2; i++) begin
        if (upd_w[i]) upd_cnt++;
        vectors++;
        if (status_w[i] !== 32'h0 || status_w[i] !== m_status[i]) begin
          miscompares++;
          $display("FAIL post_reset_status[%0d] c=%0d: got %h expected 00000000", i, c,
                   status_w[i]);
        end
      end
    end
    vectors++;
    if (upd_cnt != 0) begin
      miscompares++;
      $display("FAIL post_reset_commit: got %0d pulses expected 0", upd_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_lane_order();
    test_rst_bit();
    test_partial();
    test_same_cycle();
    test_debounce();
    test_pause_clear();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
